// File: rtl/sram_responder_if.sv
// Address and control group of the active-low external SRAM bus.
// The controller drives these signals and the responder only samples them.
interface sram_responder_if #(
    parameter int ADDR_W = 17
);
    logic [ADDR_W-1:0] SRAM_ADDR;
    logic              SRAM_UB_N;
    logic              SRAM_LB_N;
    logic              SRAM_WE_N;
    logic              SRAM_CE_N;
    logic              SRAM_OE_N;

    modport master (
        output SRAM_ADDR,
        output SRAM_UB_N,
        output SRAM_LB_N,
        output SRAM_WE_N,
        output SRAM_CE_N,
        output SRAM_OE_N
    );

    modport slave (
        input SRAM_ADDR,
        input SRAM_UB_N,
        input SRAM_LB_N,
        input SRAM_WE_N,
        input SRAM_CE_N,
        input SRAM_OE_N
    );
endinterface

// File: rtl/sram_responder.sv
// Device-side model of the 64-bit external SRAM: lane-masked writes,
// pipelined reads of programmable latency, and debug counters.
module sram_responder #(
    parameter int ADDR_W   = 17,
    parameter int DEPTH    = 65536,
    parameter int READ_LAT = 2
) (
    input  logic            clk,
    input  logic            rst,
    sram_responder_if.slave bus,
    inout  wire [63:0]      SRAM_DQ,
    output logic [15:0]     rd_count,
    output logic [15:0]     wr_count,
    output logic            oor_err
);
    localparam int          IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] DEPTH_W = 32'(DEPTH);

    typedef struct packed {
        logic        valid;
        logic        ub_n;
        logic        lb_n;
        logic [63:0] data;
    } token_t;

    logic [63:0]       mem [DEPTH];
    token_t            tok_q [READ_LAT];
    token_t            tok_d [READ_LAT];
    logic [15:0]       rd_count_q, rd_count_d;
    logic [15:0]       wr_count_q, wr_count_d;
    logic              oor_err_q, oor_err_d;
    logic [ADDR_W-1:0] addr;
    logic [IDX_W-1:0]  idx;
    logic              is_rd, is_wr, in_range;
    logic [63:0]       rd_word;
    token_t            last;
    logic              hi_en, lo_en;

    always_comb begin
        addr     = bus.SRAM_ADDR;
        idx      = addr[IDX_W-1:0];
        in_range = 32'(addr) < DEPTH_W;
        is_wr    = !bus.SRAM_CE_N && !bus.SRAM_WE_N;
        is_rd    = !bus.SRAM_CE_N && bus.SRAM_WE_N
                   && !bus.SRAM_OE_N;
        rd_word  = in_range ? mem[idx] : 64'h0;
    end

    always_comb begin
        tok_d[0].valid = is_rd;
        tok_d[0].ub_n  = bus.SRAM_UB_N;
        tok_d[0].lb_n  = bus.SRAM_LB_N;
        tok_d[0].data  = rd_word;
        for (int i = 1; i < READ_LAT; i++) begin
            tok_d[i] = tok_q[i-1];
        end
    end

    always_comb begin
        rd_count_d = rd_count_q;
        wr_count_d = wr_count_q;
        oor_err_d  = oor_err_q;
        if (is_rd && rd_count_q != 16'hFFFF) begin
            rd_count_d = rd_count_q + 16'd1;
        end
        if (is_wr && wr_count_q != 16'hFFFF) begin
            wr_count_d = wr_count_q + 16'd1;
        end
        if ((is_rd || is_wr) && !in_range) begin
            oor_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < READ_LAT; i++) begin
                tok_q[i] <= '0;
            end
            rd_count_q <= '0;
            wr_count_q <= '0;
            oor_err_q  <= 1'b0;
        end else begin
            tok_q      <= tok_d;
            rd_count_q <= rd_count_d;
            wr_count_q <= wr_count_d;
            oor_err_q  <= oor_err_d;
        end
    end

    // Storage has no reset: contents survive rst like a real chip.
    always_ff @(posedge clk) begin
        if (!rst && is_wr && in_range) begin
            if (!bus.SRAM_UB_N) begin
                mem[idx][63:32] <= SRAM_DQ[63:32];
            end
            if (!bus.SRAM_LB_N) begin
                mem[idx][31:0] <= SRAM_DQ[31:0];
            end
        end
    end

    // Current-cycle READ gates the drivers so the bus turns around at once.
    always_comb begin
        last  = tok_q[READ_LAT-1];
        hi_en = last.valid && !last.ub_n && is_rd;
        lo_en = last.valid && !last.lb_n && is_rd;
    end

    assign SRAM_DQ[63:32] = hi_en ? last.data[63:32] : 32'bz;
    assign SRAM_DQ[31:0]  = lo_en ? last.data[31:0] : 32'bz;

    assign rd_count = rd_count_q;
    assign wr_count = wr_count_q;
    assign oor_err  = oor_err_q;
endmodule

// File: tb/tb_sram_responder.sv
// Randomized and directed bench for sram_responder at latencies 1, 2 and 3,
// checked against a word-array and capture-history model of the device.
module tb_sram_responder;
    localparam int DEPTH = 1024;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sram_responder_if #(.ADDR_W(17)) bus ();

    logic        tb_drv;
    logic [63:0] tb_dq;
    wire  [63:0] dq1, dq2, dq3;
    logic [15:0] rd1, rd2, rd3, wr1, wr2, wr3;
    logic        oe1, oe2, oe3;
    logic [3:1][63:0] dqv;
    logic [3:1][15:0] rdv, wrv;
    logic [3:1]       oorv;

    assign dq1 = tb_drv ? tb_dq : 64'bz;
    assign dq2 = tb_drv ? tb_dq : 64'bz;
    assign dq3 = tb_drv ? tb_dq : 64'bz;
    assign dqv  = {dq3, dq2, dq1};
    assign rdv  = {rd3, rd2, rd1};
    assign wrv  = {wr3, wr2, wr1};
    assign oorv = {oe3, oe2, oe1};

    sram_responder #(.ADDR_W(17), .DEPTH(DEPTH), .READ_LAT(1)) u_l1 (
        .clk(clk), .rst(rst), .bus(bus), .SRAM_DQ(dq1),
        .rd_count(rd1), .wr_count(wr1), .oor_err(oe1));
    sram_responder #(.ADDR_W(17), .DEPTH(DEPTH), .READ_LAT(2)) u_l2 (
        .clk(clk), .rst(rst), .bus(bus), .SRAM_DQ(dq2),
        .rd_count(rd2), .wr_count(wr2), .oor_err(oe2));
    sram_responder #(.ADDR_W(17), .DEPTH(DEPTH), .READ_LAT(3)) u_l3 (
        .clk(clk), .rst(rst), .bus(bus), .SRAM_DQ(dq3),
        .rd_count(rd3), .wr_count(wr3), .oor_err(oe3));

    // Model: word array with per-lane "written" flags, plus the last four
    // read captures (hist[0] newest); latency L shows hist[L-1].
    typedef struct {
        bit          v;
        bit          ub_n;
        bit          lb_n;
        logic [63:0] d;
        bit   [1:0]  k;
    } tok_t;

    logic [63:0] mem [DEPTH];
    bit   [1:0]  kn  [DEPTH];
    tok_t        hist [4];
    int          m_rd, m_wr;
    bit          m_oor;
    int          pass_n = 0;
    int          total_n = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total_n++;
        if (act === exp) pass_n++;
        else $display("FAIL %s: got %h, expected %h", nm, act, exp);
    endtask

    task automatic chk_rel(input string nm, input logic [31:0] act);
        total_n++;
        if (act === 32'h0 || act === 32'hz) pass_n++;
        else $display("FAIL %s: got %h, expected released lane", nm, act);
    endtask

    task model_reset();
        for (int i = 0; i < 4; i++) hist[i].v = 1'b0;
        m_rd  = 0;
        m_wr  = 0;
        m_oor = 1'b0;
    endtask

    task model_edge();
        bit   rd, wr;
        int   a;
        tok_t t;
        if (rst) begin
            model_reset();
            return;
        end
        rd = !bus.SRAM_CE_N && bus.SRAM_WE_N && !bus.SRAM_OE_N;
        wr = !bus.SRAM_CE_N && !bus.SRAM_WE_N;
        a  = int'(bus.SRAM_ADDR);
        t.v    = rd;
        t.ub_n = bus.SRAM_UB_N;
        t.lb_n = bus.SRAM_LB_N;
        t.d    = 64'h0;
        t.k    = 2'b11;
        if (rd && a < DEPTH) begin
            t.d = mem[a];
            t.k = kn[a];
        end
        for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = t;
        if (wr && a < DEPTH) begin
            if (!bus.SRAM_UB_N) begin
                mem[a][63:32] = tb_dq[63:32];
                kn[a][1] = 1'b1;
            end
            if (!bus.SRAM_LB_N) begin
                mem[a][31:0] = tb_dq[31:0];
                kn[a][0] = 1'b1;
            end
        end
        if (rd && m_rd < 65535) m_rd++;
        if (wr && m_wr < 65535) m_wr++;
        if ((rd || wr) && a >= DEPTH) m_oor = 1'b1;
    endtask

    always @(negedge clk) begin
        bit          cur_rd, en;
        logic [31:0] act, want, tbl;
        cur_rd = !bus.SRAM_CE_N && bus.SRAM_WE_N && !bus.SRAM_OE_N;
        for (int L = 1; L <= 3; L++) begin
            for (int u = 0; u < 2; u++) begin
                act  = (u == 1) ? dqv[L][63:32] : dqv[L][31:0];
                want = (u == 1) ? hist[L-1].d[63:32] : hist[L-1].d[31:0];
                tbl  = (u == 1) ? tb_dq[63:32] : tb_dq[31:0];
                en = !rst && cur_rd && hist[L-1].v
                     && !((u == 1) ? hist[L-1].ub_n : hist[L-1].lb_n);
                if (en) begin
                    if (hist[L-1].k[u])
                        chk($sformatf("dq_l%0d_lane%0d", L, u),
                            64'(act), 64'(want));
                end else if (tb_drv) begin
                    chk($sformatf("dq_bench_l%0d_lane%0d", L, u),
                        64'(act), 64'(tbl));
                end else begin
                    chk_rel($sformatf("dq_rel_l%0d_lane%0d", L, u), act);
                end
            end
            chk($sformatf("rd_count_l%0d", L), 64'(rdv[L]), 64'(m_rd));
            chk($sformatf("wr_count_l%0d", L), 64'(wrv[L]), 64'(m_wr));
            chk($sformatf("oor_err_l%0d", L), 64'(oorv[L]), 64'(m_oor));
        end
    end

    task setb(input logic [16:0] a, input bit ce, input bit we,
              input bit oe, input bit ub, input bit lb,
              input bit drv, input logic [63:0] d);
        bus.SRAM_ADDR = a;
        bus.SRAM_CE_N = ce;
        bus.SRAM_WE_N = we;
        bus.SRAM_OE_N = oe;
        bus.SRAM_UB_N = ub;
        bus.SRAM_LB_N = lb;
        tb_drv = drv;
        tb_dq  = d;
    endtask

    task do_wr(input logic [16:0] a, input logic [63:0] d,
               input bit ub, input bit lb);
        setb(a, 1'b0, 1'b0, 1'b1, ub, lb, 1'b1, d);
    endtask

    task do_rd(input logic [16:0] a, input bit ub, input bit lb);
        setb(a, 1'b0, 1'b1, 1'b0, ub, lb, 1'b0, 64'h0);
    endtask

    task do_idle();
        setb(17'h0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 64'h0);
    endtask

    task tick(input int n);
        repeat (n) begin
            @(posedge clk);
            model_edge();
            #1;
        end
    endtask

    task neg();
        @(negedge clk);
        #1;
    endtask

    task pulse_rst();
        rst = 1'b1;
        model_reset();
        #2;
        rst = 1'b0;
    endtask

    initial begin
        logic [16:0] a;
        bit          ce, we, oe, ub, lb, rdc, drv;
        for (int i = 0; i < DEPTH; i++) kn[i] = 2'b00;
        rst = 1'b1;
        do_idle();
        model_reset();
        tick(2);
        neg();
        rst = 1'b0;

        // Preload, then reset with a READ held on the bus.
        do_wr(17'h10, 64'h0123_4567_89AB_CDEF, 1'b0, 1'b0);
        tick(1);
        do_rd(17'h10, 1'b0, 1'b0);
        rst = 1'b1;
        model_reset();
        tick(2);
        neg();
        chk_rel("rst_z_l1_hi", dq1[63:32]);
        chk_rel("rst_z_l2_lo", dq2[31:0]);
        chk_rel("rst_z_l3_hi", dq3[63:32]);
        chk("rst_rd_count", 64'(rd2), 64'h0);
        chk("rst_wr_count", 64'(wr2), 64'h0);
        chk("rst_oor_err", 64'(oe2), 64'h0);
        rst = 1'b0;
        tick(1);
        neg();
        chk("lat1_after_e0", dq1, 64'h0123_4567_89AB_CDEF);
        chk_rel("lat2_not_yet", dq2[63:32]);
        tick(1);
        neg();
        chk("lat2_after_e1", dq2, 64'h0123_4567_89AB_CDEF);
        chk_rel("lat3_not_yet", dq3[31:0]);
        tick(1);
        neg();
        chk("lat3_after_e2", dq3, 64'h0123_4567_89AB_CDEF);

        // Write three times, read six times.
        do_idle();
        pulse_rst();
        do_wr(17'h5, 64'h0000_0000_DEAD_BEEF, 1'b0, 1'b0);
        tick(3);
        do_rd(17'h5, 1'b0, 1'b0);
        tick(2);
        neg();
        chk("wr_rd_data", dq2, 64'h0000_0000_DEAD_BEEF);
        tick(4);
        do_idle();
        neg();
        chk("wr_rd_wr_count", 64'(wr2), 64'd3);
        chk("wr_rd_rd_count", 64'(rd2), 64'd6);

        // Byte lanes.
        do_wr(17'h7, 64'h1111_2222_3333_4444, 1'b0, 1'b0);
        tick(1);
        do_wr(17'h7, 64'hAAAA_BBBB_CCCC_DDDD, 1'b1, 1'b0);
        tick(1);
        do_rd(17'h7, 1'b0, 1'b0);
        tick(2);
        neg();
        chk("lane_merge", dq2, 64'h1111_2222_CCCC_DDDD);
        do_rd(17'h7, 1'b0, 1'b1);
        tick(2);
        neg();
        chk("lane_hi_only", 64'(dq2[63:32]), 64'h1111_2222);
        chk_rel("lane_lo_z", dq2[31:0]);

        // Read stream, then WE_N falls: responder must let go in that cycle.
        do_rd(17'h7, 1'b0, 1'b0);
        tick(3);
        do_wr(17'h8, 64'h5A5A_5A5A_A5A5_A5A5, 1'b0, 1'b0);
        neg();
        chk("turn_l1", dq1, 64'h5A5A_5A5A_A5A5_A5A5);
        chk("turn_l2", dq2, 64'h5A5A_5A5A_A5A5_A5A5);
        chk("turn_l3", dq3, 64'h5A5A_5A5A_A5A5_A5A5);
        tick(1);

        // Out of range: no aliasing onto word 0, error sticks, reads zero.
        do_wr(17'h0, 64'h0BAD_F00D_0000_0001, 1'b0, 1'b0);
        tick(1);
        do_wr(17'h400, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
        tick(1);
        do_idle();
        neg();
        chk("oor_set_l1", 64'(oe1), 64'h1);
        chk("oor_set_l3", 64'(oe3), 64'h1);
        tick(3);
        neg();
        chk("oor_sticky", 64'(oe2), 64'h1);
        do_rd(17'h0, 1'b0, 1'b0);
        tick(2);
        neg();
        chk("oor_no_alias", dq2, 64'h0BAD_F00D_0000_0001);
        do_rd(17'h400, 1'b0, 1'b0);
        tick(2);
        neg();
        chk("oor_rd_zero", dq2, 64'h0);

        // Reset in the middle of a read stream.
        do_rd(17'h5, 1'b0, 1'b0);
        tick(3);
        rst = 1'b1;
        model_reset();
        #1;
        chk_rel("rst_mid_l1", dq1[31:0]);
        chk_rel("rst_mid_l2", dq2[31:0]);
        chk_rel("rst_mid_l3", dq3[63:32]);
        neg();
        rst = 1'b0;
        tick(3);
        neg();
        chk("rst_keeps_array", dq2, 64'h0000_0000_DEAD_BEEF);

        // Random traffic; the bench drives DQ only outside READ cycles.
        repeat (4000) begin
            if ($urandom_range(0, 15) == 0)
                a = 17'($urandom_range(1024, 131071));
            else
                a = 17'($urandom_range(0, 15));
            ce  = ($urandom_range(0, 7) == 0);
            we  = ($urandom_range(0, 2) != 0);
            oe  = ($urandom_range(0, 5) == 0);
            ub  = ($urandom_range(0, 3) == 0);
            lb  = ($urandom_range(0, 3) == 0);
            rdc = !ce && we && !oe;
            drv = rdc ? 1'b0 : (!ce && !we) ? 1'b1 : 1'($urandom_range(0, 1));
            setb(a, ce, we, oe, ub, lb, drv, {$urandom, $urandom});
            if ($urandom_range(0, 299) == 0) pulse_rst();
            tick(1);
        end

        // Saturation of the read counter.
        do_idle();
        pulse_rst();
        repeat (70000) begin
            do_rd(17'($urandom_range(0, 15)), 1'b0, 1'b0);
            tick(1);
        end
        do_idle();
        neg();
        chk("sat_rd_l1", 64'(rd1), 64'hFFFF);
        chk("sat_rd_l2", 64'(rd2), 64'hFFFF);
        chk("sat_rd_l3", 64'(rd3), 64'hFFFF);
        chk("sat_wr_zero", 64'(wr2), 64'h0);

        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end
endmodule
